// File: rtl/noc_pkg.sv
`default_nettype none
//==============================================================================
// noc_pkg : flit layout, NoC constants and shared types for PE/controller ports
// Rev 1.0
//==============================================================================
package noc_pkg;

   localparam int FLIT_DATA_WIDTH = 64;
   localparam int DEST_BITS       = 5;
   localparam int VC_BITS         = 2;
   localparam int FLIT_WIDTH      = 1 + 1 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;

   localparam int FLIT_VALID      = 72;
   localparam int FLIT_TAIL       = 71;
   localparam int FLIT_DEST_HI    = 70;
   localparam int FLIT_DEST_LO    = 66;
   localparam int FLIT_VC_HI      = 65;
   localparam int FLIT_VC_LO      = 64;

   localparam int HDR_FLITS       = 10;
   localparam int HDR_WIDTH       = HDR_FLITS * FLIT_DATA_WIDTH;
   localparam int CNT_BITS        = 4;

   localparam int CREDIT_DEPTH    = 16;
   localparam int CRED_BITS       = 5;
   localparam int CTRL_DEST       = 0;
   localparam int TX_VC           = 0;

   localparam logic [FLIT_DATA_WIDTH-1:0] FOUND_BITCOIN_MSG = 64'h1;

   typedef logic [FLIT_WIDTH-1:0] flit_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_FOUND = 2'd1,
      TX_NONCE = 2'd2,
      TX_CLKS  = 2'd3
   } tx_state_t;

   function automatic flit_t make_flit(
      input logic                       tail,
      input logic [DEST_BITS-1:0]       dest,
      input logic [VC_BITS-1:0]         vc,
      input logic [FLIT_DATA_WIDTH-1:0] data
   );
      return {1'b1, tail, dest, vc, data};
   endfunction

endpackage
`default_nettype wire

// File: rtl/pe_net_if_if.sv
`default_nettype none
//==============================================================================
// pe_net_if_if : router-port and mining-core signals of one PE endpoint
// Rev 1.0
//==============================================================================
interface pe_net_if_if;
   import noc_pkg::*;

   logic [FLIT_WIDTH-1:0] getFlit;
   logic                  EN_getFlit;
   logic [VC_BITS:0]      putCredits;
   logic                  EN_putCredits;
   logic [FLIT_WIDTH-1:0] putFlit;
   logic                  EN_putFlit;
   logic [VC_BITS:0]      getCredits;
   logic                  EN_getCredits;
   logic [HDR_WIDTH-1:0]  hdr_data;
   logic                  hdr_valid;
   logic                  hdr_ready;
   logic                  res_valid;
   logic [31:0]           res_nonce;
   logic [63:0]           res_clks;
   logic                  res_ready;
   logic                  rx_err;

   modport slave (
      input  getFlit, getCredits, hdr_ready, res_valid, res_nonce, res_clks,
      output EN_getFlit, putCredits, EN_putCredits, putFlit, EN_putFlit,
             EN_getCredits, hdr_data, hdr_valid, res_ready, rx_err
   );

   modport master (
      output getFlit, getCredits, hdr_ready, res_valid, res_nonce, res_clks,
      input  EN_getFlit, putCredits, EN_putCredits, putFlit, EN_putFlit,
             EN_getCredits, hdr_data, hdr_valid, res_ready, rx_err
   );

endinterface
`default_nettype wire

// File: rtl/pe_tx_credit.sv
`default_nettype none
//==============================================================================
// pe_tx_credit : TX credit counter and 3-flit result sender (FOUND, nonce, clks)
// Rev 1.0
//==============================================================================
module pe_tx_credit
   import noc_pkg::*;
#(
   parameter int INIT_CREDITS = CREDIT_DEPTH,
   parameter int RESULT_DEST  = CTRL_DEST,
   parameter int RESULT_VC    = TX_VC
)
(
   input  wire                   sys_clk,
   input  wire                   reset,
   input  wire                   res_valid,
   input  wire  [31:0]           res_nonce,
   input  wire  [63:0]           res_clks,
   output logic                  res_ready,
   input  wire                   credit_in,
   output logic [FLIT_WIDTH-1:0] put_flit,
   output logic                  put_flit_en
);

   localparam logic [DEST_BITS-1:0] c_dest     = DEST_BITS'(RESULT_DEST);
   localparam logic [VC_BITS-1:0]   c_vc       = VC_BITS'(RESULT_VC);
   localparam logic [CRED_BITS-1:0] c_max_cred = CRED_BITS'(INIT_CREDITS);

   tx_state_t            r_state;
   tx_state_t            w_state_next;
   logic [CRED_BITS-1:0] r_cred;
   logic [CRED_BITS-1:0] w_cred_next;
   logic [31:0]          r_nonce;
   logic [63:0]          r_clks;
   logic                 w_send;
   logic                 w_capture;
   logic                 w_has_cred;
   flit_t                w_flit;
   flit_t                r_put_flit;
   logic                 r_put_en;

   assign w_has_cred = (r_cred != '0);

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) r_state <= TX_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_send       = 1'b0;
      w_capture    = 1'b0;
      w_flit       = '0;
      case (r_state)
         TX_IDLE: begin
            if (res_valid) begin
               w_capture    = 1'b1;
               w_state_next = TX_FOUND;
            end
         end
         TX_FOUND: begin
            if (w_has_cred) begin
               w_send       = 1'b1;
               w_flit       = make_flit(1'b0, c_dest, c_vc, FOUND_BITCOIN_MSG);
               w_state_next = TX_NONCE;
            end
         end
         TX_NONCE: begin
            if (w_has_cred) begin
               w_send       = 1'b1;
               w_flit       = make_flit(1'b0, c_dest, c_vc, {32'h0, r_nonce});
               w_state_next = TX_CLKS;
            end
         end
         TX_CLKS: begin
            if (w_has_cred) begin
               w_send       = 1'b1;
               w_flit       = make_flit(1'b1, c_dest, c_vc, r_clks);
               w_state_next = TX_IDLE;
            end
         end
         default: w_state_next = TX_IDLE;
      endcase
   end

   // Send and return in the same cycle cancel; returns beyond the router depth are dropped.
   always_comb begin
      w_cred_next = r_cred;
      if (w_send && !credit_in)
         w_cred_next = r_cred - CRED_BITS'(1);
      else if (!w_send && credit_in && (r_cred < c_max_cred))
         w_cred_next = r_cred + CRED_BITS'(1);
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         r_cred     <= c_max_cred;
         r_nonce    <= '0;
         r_clks     <= '0;
         r_put_flit <= '0;
         r_put_en   <= 1'b0;
      end else begin
         r_cred     <= w_cred_next;
         r_put_flit <= w_flit;
         r_put_en   <= w_send;
         if (w_capture) begin
            r_nonce <= res_nonce;
            r_clks  <= res_clks;
         end
      end
   end

   assign res_ready   = w_capture;
   assign put_flit    = r_put_flit;
   assign put_flit_en = r_put_en;

endmodule
`default_nettype wire

// File: rtl/pe_net_if.sv
`default_nettype none
//==============================================================================
// pe_net_if : PE-side NoC endpoint - block-header reassembly and result injection
// Rev 1.0
//==============================================================================
module pe_net_if
   import noc_pkg::*;
(
   input  wire         sys_clk,
   input  wire         reset,
   pe_net_if_if.slave  net
);

   localparam logic [CNT_BITS-1:0] c_last_slot = CNT_BITS'(HDR_FLITS - 1);

   logic [CNT_BITS-1:0]        r_rx_cnt;
   logic [FLIT_DATA_WIDTH-1:0] r_asm [HDR_FLITS-1];
   logic [HDR_WIDTH-1:0]       r_hdr_data;
   logic [HDR_WIDTH-1:0]       w_hdr_next;
   logic                       r_hdr_valid;
   logic                       r_rx_err;
   logic                       r_cred_en;
   logic [VC_BITS-1:0]         r_cred_vc;
   logic                       w_rx_open;
   logic                       w_accept;
   logic                       w_tail;
   logic                       w_last;
   logic                       w_complete;
   logic                       w_frame_err;
   logic                       w_unused;

   assign w_last      = (r_rx_cnt == c_last_slot);
   // Only the closing flit of a new header must wait for the core to drain the previous one.
   assign w_rx_open   = ~(r_hdr_valid & ~net.hdr_ready & w_last);
   assign w_accept    = w_rx_open & net.getFlit[FLIT_VALID];
   assign w_tail      = net.getFlit[FLIT_TAIL];
   assign w_complete  = w_accept & w_tail & w_last;
   assign w_frame_err = w_accept & (w_tail ^ w_last);

   // The final flit goes straight into the output header; only the first nine are buffered.
   always_comb begin
      w_hdr_next = '0;
      for (int i = 0; i < HDR_FLITS - 1; i++)
         w_hdr_next[i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH] = r_asm[i];
      w_hdr_next[HDR_WIDTH-1 -: FLIT_DATA_WIDTH] = net.getFlit[FLIT_DATA_WIDTH-1:0];
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         r_rx_cnt    <= '0;
         r_hdr_data  <= '0;
         r_hdr_valid <= 1'b0;
         r_rx_err    <= 1'b0;
         r_cred_en   <= 1'b0;
         r_cred_vc   <= '0;
         for (int i = 0; i < HDR_FLITS - 1; i++)
            r_asm[i] <= '0;
      end else begin
         if (w_accept) begin
            for (int i = 0; i < HDR_FLITS - 1; i++)
               if (r_rx_cnt == CNT_BITS'(i))
                  r_asm[i] <= net.getFlit[FLIT_DATA_WIDTH-1:0];
            if (w_complete || w_frame_err) r_rx_cnt <= '0;
            else                           r_rx_cnt <= r_rx_cnt + CNT_BITS'(1);
            if (w_frame_err) r_rx_err <= 1'b1;
         end
         if (w_complete) begin
            r_hdr_data  <= w_hdr_next;
            r_hdr_valid <= 1'b1;
         end else if (r_hdr_valid && net.hdr_ready) begin
            r_hdr_valid <= 1'b0;
         end
         r_cred_en <= w_accept;
         r_cred_vc <= w_accept ? net.getFlit[FLIT_VC_HI:FLIT_VC_LO] : '0;
      end
   end

   assign net.EN_getFlit    = w_rx_open;
   assign net.putCredits    = {r_cred_en, r_cred_vc};
   assign net.EN_putCredits = r_cred_en;
   assign net.EN_getCredits = 1'b1;
   assign net.hdr_data      = r_hdr_data;
   assign net.hdr_valid     = r_hdr_valid;
   assign net.rx_err        = r_rx_err;

   assign w_unused = ^{net.getFlit[FLIT_DEST_HI:FLIT_DEST_LO], net.getCredits[VC_BITS-1:0]};

   pe_tx_credit #(
      .INIT_CREDITS (CREDIT_DEPTH),
      .RESULT_DEST  (CTRL_DEST),
      .RESULT_VC    (TX_VC)
   ) u_tx_credit (
      .sys_clk     (sys_clk),
      .reset       (reset),
      .res_valid   (net.res_valid),
      .res_nonce   (net.res_nonce),
      .res_clks    (net.res_clks),
      .res_ready   (net.res_ready),
      .credit_in   (net.getCredits[VC_BITS]),
      .put_flit    (net.putFlit),
      .put_flit_en (net.EN_putFlit)
   );

endmodule
`default_nettype wire

// File: tb/tb_pe_net_if.sv
`default_nettype none
//==============================================================================
// tb_pe_net_if : directed stimulus with a queue-based reference of the PE endpoint
// Rev 1.0
//==============================================================================
module tb_pe_net_if;
   import noc_pkg::*;

   logic sys_clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   pe_net_if_if bus ();

   pe_net_if dut (
      .sys_clk (sys_clk),
      .reset   (reset),
      .net     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference state
   int          m_cnt;
   logic        m_hv;
   logic [639:0] m_hdr;
   logic        m_err;
   logic [63:0] m_slot [10];
   logic        m_pc_en;
   logic [1:0]  m_pc_vc;
   logic [72:0] m_txq [$];
   int          m_cred;
   logic        m_put_en;
   logic [72:0] m_put;
   bit          m_last_acc;
   bit          m_last_cap;

   int          n_cred_seen = 0;
   logic [72:0] tx_log [$];

   function automatic logic [72:0] tx_flit(input logic tail, input logic [63:0] d);
      return {1'b1, tail, 5'd0, 2'd0, d};
   endfunction

   task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge sys_clk or posedge reset) begin : model
      logic        acc;
      logic        done;
      logic        snd;
      logic        idle;
      logic [72:0] f;
      if (reset) begin
         m_cnt = 0; m_hv = 1'b0; m_hdr = '0; m_err = 1'b0;
         for (int k = 0; k < 10; k++) m_slot[k] = '0;
         m_pc_en = 1'b0; m_pc_vc = 2'd0;
         m_txq.delete();
         m_cred = 16; m_put_en = 1'b0; m_put = '0;
         m_last_acc = 1'b0; m_last_cap = 1'b0;
      end else begin
         f    = bus.getFlit;
         acc  = f[72] && !(m_hv && !bus.hdr_ready && m_cnt == 9);
         done = acc && f[71] && (m_cnt == 9);
         m_pc_en = acc;
         m_pc_vc = acc ? f[65:64] : 2'd0;
         if (acc) begin
            if (done) begin
               for (int k = 0; k < 9; k++) m_hdr[64*k +: 64] = m_slot[k];
               m_hdr[576 +: 64] = f[63:0];
               m_cnt = 0;
            end else if (f[71] || m_cnt == 9) begin
               m_err = 1'b1;
               m_cnt = 0;
            end else begin
               m_slot[m_cnt] = f[63:0];
               m_cnt++;
            end
         end
         if (done) m_hv = 1'b1;
         else if (m_hv && bus.hdr_ready) m_hv = 1'b0;

         idle = (m_txq.size() == 0);
         snd  = !idle && (m_cred > 0);
         if (snd) begin
            m_put = m_txq.pop_front();
            m_put_en = 1'b1;
         end else begin
            m_put = '0;
            m_put_en = 1'b0;
         end
         m_last_cap = idle && bus.res_valid;
         if (m_last_cap) begin
            m_txq.push_back(tx_flit(1'b0, 64'h1));
            m_txq.push_back(tx_flit(1'b0, {32'h0, bus.res_nonce}));
            m_txq.push_back(tx_flit(1'b1, bus.res_clks));
         end
         if (snd && !bus.getCredits[2]) m_cred--;
         else if (!snd && bus.getCredits[2] && m_cred < 16) m_cred++;
         m_last_acc = acc;
      end
   end

   always @(negedge sys_clk) begin
      chk("EN_getFlit",    bus.EN_getFlit,    !(m_hv && !bus.hdr_ready && m_cnt == 9));
      chk("EN_getCredits", bus.EN_getCredits, 1'b1);
      chk("putCredits",    bus.putCredits,    {m_pc_en, m_pc_vc});
      chk("EN_putCredits", bus.EN_putCredits, m_pc_en);
      chk("putFlit",       bus.putFlit,       m_put);
      chk("EN_putFlit",    bus.EN_putFlit,    m_put_en);
      chk("hdr_valid",     bus.hdr_valid,     m_hv);
      chk("hdr_data",      bus.hdr_data,      m_hdr);
      chk("rx_err",        bus.rx_err,        m_err);
      chk("res_ready",     bus.res_ready,     (m_txq.size() == 0) && bus.res_valid);
      if (bus.EN_putCredits === 1'b1) n_cred_seen++;
      if (bus.EN_putFlit === 1'b1) tx_log.push_back(bus.putFlit);
   end

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic drive_flit(input logic tail, input logic [1:0] vc, input logic [63:0] d);
      bus.getFlit = {1'b1, tail, 5'd3, vc, d};
   endtask

   task automatic wait_acc(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge sys_clk);
         #1;
         got = m_last_acc;
      end
      if (!got) begin
         n_tests++; n_fail++;
         $display("FAIL %s: flit not accepted within 40 cycles", name);
      end
   endtask

   task automatic send_flit(input logic tail, input logic [1:0] vc, input logic [63:0] d);
      drive_flit(tail, vc, d);
      wait_acc("flit_accept");
      bus.getFlit = '0;
   endtask

   task automatic send_hdr(input logic [63:0] base);
      for (int k = 0; k < 10; k++)
         send_flit(k == 9, 2'(k % 4), base + 64'(k));
   endtask

   task automatic check_hdr(input string name, input logic [63:0] base);
      for (int k = 0; k < 10; k++)
         chk(name, bus.hdr_data[64*k +: 64], base + 64'(k));
   endtask

   task automatic do_result(input logic [31:0] nonce, input logic [63:0] clks);
      bit got = 1'b0;
      bus.res_valid = 1'b1;
      bus.res_nonce = nonce;
      bus.res_clks  = clks;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge sys_clk);
         #1;
         got = m_last_cap;
      end
      bus.res_valid = 1'b0;
      if (!got) begin
         n_tests++; n_fail++;
         $display("FAIL result_capture: res not captured within 40 cycles");
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int t0;
      bus.getFlit = '0; bus.getCredits = '0; bus.hdr_ready = 1'b0;
      bus.res_valid = 1'b0; bus.res_nonce = '0; bus.res_clks = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(negedge sys_clk);
      chk("rst_en_getflit",    bus.EN_getFlit, 1'b1);
      chk("rst_en_getcredits", bus.EN_getCredits, 1'b1);
      chk("rst_hdr_valid",     bus.hdr_valid, 1'b0);
      chk("rst_en_putflit",    bus.EN_putFlit, 1'b0);
      @(posedge sys_clk); #1 reset = 1'b0;

      // Surplus credits while full must not raise the count
      bus.getCredits = 3'b100;
      idle_cycles(3);
      bus.getCredits = 3'b000;

      // Header 1, core not ready
      c0 = n_cred_seen;
      send_hdr(64'd0);
      @(negedge sys_clk);
      chk("hdr1_valid", bus.hdr_valid, 1'b1);
      check_hdr("hdr1_word", 64'd0);
      @(negedge sys_clk);
      chk("hdr1_credits", 32'(n_cred_seen - c0), 32'd10);

      // Header 2 under backpressure
      c0 = n_cred_seen;
      for (int k = 0; k < 9; k++) send_flit(1'b0, 2'(k % 4), 64'd100 + 64'(k));
      drive_flit(1'b1, 2'd1, 64'd109);
      idle_cycles(4);
      @(negedge sys_clk);
      chk("bp_en_getflit", bus.EN_getFlit, 1'b0);
      chk("bp_credits_9", 32'(n_cred_seen - c0), 32'd9);
      @(posedge sys_clk); #1 bus.hdr_ready = 1'b1;
      wait_acc("bp_release");
      bus.getFlit = '0;
      @(negedge sys_clk);
      chk("hdr2_valid", bus.hdr_valid, 1'b1);
      check_hdr("hdr2_word", 64'd100);
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk("bp_credits_10", 32'(n_cred_seen - c0), 32'd10);
      chk("hdr2_drained", bus.hdr_valid, 1'b0);

      // Framing error: tail on the 4th flit
      c0 = n_cred_seen;
      send_flit(1'b0, 2'd0, 64'd500);
      send_flit(1'b0, 2'd1, 64'd501);
      send_flit(1'b0, 2'd2, 64'd502);
      send_flit(1'b1, 2'd3, 64'd503);
      idle_cycles(2);
      @(negedge sys_clk);
      chk("frm_rx_err", bus.rx_err, 1'b1);
      chk("frm_no_hdr", bus.hdr_valid, 1'b0);
      chk("frm_credits", 32'(n_cred_seen - c0), 32'd4);
      send_hdr(64'd200);
      @(negedge sys_clk);
      chk("hdr3_valid", bus.hdr_valid, 1'b1);
      check_hdr("hdr3_word", 64'd200);

      // Result report
      t0 = tx_log.size();
      do_result(32'hDEADBEEF, 64'h1234);
      idle_cycles(6);
      @(negedge sys_clk);
      chk("res_nflits", 32'(tx_log.size() - t0), 32'd3);
      if (tx_log.size() >= t0 + 3) begin
         chk("res_found", tx_log[t0],     {1'b1, 1'b0, 5'd0, 2'd0, 64'h1});
         chk("res_nonce", tx_log[t0 + 1], {1'b1, 1'b0, 5'd0, 2'd0, 64'hDEADBEEF});
         chk("res_clks",  tx_log[t0 + 2], {1'b1, 1'b1, 5'd0, 2'd0, 64'h1234});
      end

      // Four more reports leave one credit
      for (int r = 0; r < 4; r++) begin
         do_result(32'(r + 1), 64'(r + 10));
         idle_cycles(5);
      end

      // Credit starvation
      t0 = tx_log.size();
      do_result(32'hCAFEF00D, 64'h5678);
      idle_cycles(8);
      @(negedge sys_clk);
      chk("starve_one_flit", 32'(tx_log.size() - t0), 32'd1);
      @(posedge sys_clk); #1 bus.getCredits = 3'b100;
      @(posedge sys_clk); #1;
      @(posedge sys_clk); #1 bus.getCredits = 3'b000;
      idle_cycles(4);
      @(negedge sys_clk);
      chk("starve_resumed", 32'(tx_log.size() - t0), 32'd3);
      if (tx_log.size() >= t0 + 3) begin
         chk("starve_nonce", tx_log[t0 + 1], {1'b1, 1'b0, 5'd0, 2'd0, 64'hCAFEF00D});
         chk("starve_clks",  tx_log[t0 + 2], {1'b1, 1'b1, 5'd0, 2'd0, 64'h5678});
      end
      t0 = tx_log.size();
      do_result(32'h1, 64'h1);
      idle_cycles(6);
      @(negedge sys_clk);
      chk("starve_empty", 32'(tx_log.size() - t0), 32'd0);

      // Reset mid-header and with a stalled report
      for (int k = 0; k < 5; k++) send_flit(1'b0, 2'(k % 4), 64'd300 + 64'(k));
      @(posedge sys_clk); #1 reset = 1'b1;
      @(negedge sys_clk);
      chk("mid_rst_en_getflit", bus.EN_getFlit, 1'b1);
      chk("mid_rst_rx_err",     bus.rx_err, 1'b0);
      chk("mid_rst_putflit",    bus.putFlit, 73'd0);
      chk("mid_rst_putcred",    bus.EN_putCredits, 1'b0);
      @(posedge sys_clk); #1 reset = 1'b0;
      t0 = tx_log.size();
      idle_cycles(6);
      @(negedge sys_clk);
      chk("rst_result_dropped", 32'(tx_log.size() - t0), 32'd0);
      send_hdr(64'd400);
      @(negedge sys_clk);
      chk("hdr4_valid", bus.hdr_valid, 1'b1);
      check_hdr("hdr4_word", 64'd400);
      idle_cycles(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
